// File: rtl/jtag_master.sv
// JTAG master: runs one TAP command at a time (reset, IR shift, DR shift, idle clocks)
// with TCK divided down from the system clock, and returns the captured TDO bits.
module jtag_master #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 64
) (
  input  logic               clock,
  input  logic               resetb,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [6:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               jtag_tck,
  output logic               jtag_tms,
  output logic               jtag_tdi,
  input  logic               jtag_tdo,
  output logic [1:0]         dbg_state
);

  // Handshake: a command transfers on the clock edge where cmd_valid && cmd_ready
  // (cmd_ready is high only in S_IDLE); rsp_valid is a one-cycle pulse with no ready.

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_SHIFT, S_POST} state_t;

  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_IR    = 2'd1;
  localparam logic [1:0] OP_DR    = 2'd2;
  localparam logic [1:0] OP_IDLE  = 2'd3;

  localparam int              DW       = $clog2(CLK_DIV);
  localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [6:0]      LEN_MAX  = 7'(MAX_LEN);
  localparam logic [MAX_LEN-1:0] ONE   = {{(MAX_LEN-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [1:0]           op_q;
  logic [6:0]           len_q;
  logic [MAX_LEN-1:0]   data_q;
  logic [MAX_LEN-1:0]   cap_q;
  logic [DW-1:0]        div_q;
  logic [6:0]           idx_q;
  logic                 fin_q;

  logic                 accept;
  logic                 evt;
  logic                 fall_evt;
  logic                 rise_evt;
  logic                 shift_op;
  logic [6:0]           len_clamped;
  logic [6:0]           phase_len;
  logic                 phase_last;
  logic                 phase_done;
  logic                 tms_bit;
  logic                 tdi_bit;
  logic [MAX_LEN-1:0]   sel_mask;

  always_comb begin
    cmd_ready   = (state_q == S_IDLE);
    busy        = (state_q != S_IDLE);
    dbg_state   = state_q;
    accept      = cmd_valid && (state_q == S_IDLE);
    // One TCK half-period event every CLK_DIV cycles; the first lands on the cycle after accept.
    evt         = (state_q != S_IDLE) && (div_q == '0);
    fall_evt    = evt && jtag_tck;
    rise_evt    = evt && !jtag_tck;
    shift_op    = (op_q == OP_IR) || (op_q == OP_DR);
    sel_mask    = ONE << idx_q;

    len_clamped = cmd_len;
    if (cmd_len == 7'd0) begin
      len_clamped = 7'd1;
    end else if (cmd_len > LEN_MAX) begin
      len_clamped = LEN_MAX;
    end

    phase_len = 7'd1;
    case (state_q)
      S_PRE: begin
        case (op_q)
          OP_RESET: phase_len = 7'd6;
          OP_IR:    phase_len = 7'd4;
          default:  phase_len = 7'd3;
        endcase
      end
      S_SHIFT: phase_len = len_q;
      S_POST:  phase_len = 7'd2;
      default: phase_len = 7'd1;
    endcase
    phase_last = (idx_q == phase_len - 7'd1);

    // TAP_RESET lives entirely in S_PRE, IDLE_CLK entirely in S_SHIFT.
    phase_done = rise_evt && phase_last &&
                 ((state_q == S_POST) ||
                  ((state_q == S_PRE) && (op_q == OP_RESET)) ||
                  ((state_q == S_SHIFT) && (op_q == OP_IDLE)));

    tms_bit = 1'b1;
    case (state_q)
      S_PRE: begin
        case (op_q)
          OP_RESET: tms_bit = (idx_q < 7'd5);
          OP_IR:    tms_bit = (idx_q < 7'd2);
          default:  tms_bit = (idx_q == 7'd0);
        endcase
      end
      S_SHIFT: tms_bit = shift_op && phase_last;
      S_POST:  tms_bit = (idx_q == 7'd0);
      default: tms_bit = 1'b1;
    endcase

    tdi_bit = 1'b1;
    if ((state_q == S_SHIFT) && shift_op) begin
      tdi_bit = |(data_q & sel_mask);
    end

    state_d = state_q;
    if (accept) begin
      state_d = (cmd_op == OP_IDLE) ? S_SHIFT : S_PRE;
    end else if (fall_evt && fin_q) begin
      state_d = S_IDLE;
    end else if (rise_evt && phase_last && !phase_done) begin
      state_d = (state_q == S_PRE) ? S_SHIFT : S_POST;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q   <= S_IDLE;
      op_q      <= 2'd0;
      len_q     <= 7'd0;
      data_q    <= '0;
      cap_q     <= '0;
      div_q     <= '0;
      idx_q     <= 7'd0;
      fin_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      jtag_tck  <= 1'b1;
      jtag_tms  <= 1'b1;
      jtag_tdi  <= 1'b1;
    end else begin
      state_q   <= state_d;
      rsp_valid <= 1'b0;
      if (accept) begin
        op_q   <= cmd_op;
        len_q  <= len_clamped;
        data_q <= cmd_data;
        cap_q  <= '0;
        div_q  <= '0;
        idx_q  <= 7'd0;
        fin_q  <= 1'b0;
      end else if (state_q != S_IDLE) begin
        div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        if (fall_evt) begin
          if (fin_q) begin
            // Response slot: the would-be next falling edge; TCK stays high.
            rsp_valid <= 1'b1;
            rsp_data  <= cap_q;
            fin_q     <= 1'b0;
            div_q     <= '0;
          end else begin
            jtag_tck <= 1'b0;
            jtag_tms <= tms_bit;
            jtag_tdi <= tdi_bit;
          end
        end else if (rise_evt) begin
          jtag_tck <= 1'b1;
          // TDO was driven by the target on the previous TCK fall.
          if ((state_q == S_SHIFT) && shift_op && jtag_tdo) begin
            cap_q <= cap_q | sel_mask;
          end
          idx_q <= phase_last ? 7'd0 : idx_q + 7'd1;
          if (phase_done) begin
            fin_q <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master: a behavioural 1149.1 TAP target (IR 6 bits, IDCODE 0x14d57048),
// a table of directed commands and hand-written multi-cycle sequences.
module tb_jtag_master;

  localparam int W = 64;
  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_IR    = 2'd1;
  localparam logic [1:0] OP_DR    = 2'd2;
  localparam logic [1:0] OP_IDLE  = 2'd3;
  localparam logic [31:0] IDCODE  = 32'h14d57048;

  logic         clock = 1'b0;
  logic         resetb = 1'b1;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [6:0]   cmd_len;
  logic [W-1:0] cmd_data;
  logic         rsp_valid;
  logic [W-1:0] rsp_data;
  logic         busy;
  logic         jtag_tck;
  logic         jtag_tms;
  logic         jtag_tdi;
  logic         jtag_tdo;
  logic [1:0]   dbg_state;

  always #5 clock = ~clock;

  jtag_master #(.CLK_DIV(2), .MAX_LEN(W)) dut (
    .clock     (clock),
    .resetb    (resetb),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .jtag_tck  (jtag_tck),
    .jtag_tms  (jtag_tms),
    .jtag_tdi  (jtag_tdi),
    .jtag_tdo  (jtag_tdo),
    .dbg_state (dbg_state)
  );

  // ---------------- TAP target model ----------------
  typedef enum logic [3:0] {TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
                            SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR} tap_t;

  function automatic tap_t tap_next(input tap_t s, input logic tms);
    case (s)
      TLR:     return tms ? TLR    : RTI;
      RTI:     return tms ? SEL_DR : RTI;
      SEL_DR:  return tms ? SEL_IR : CAP_DR;
      CAP_DR:  return tms ? EX1_DR : SH_DR;
      SH_DR:   return tms ? EX1_DR : SH_DR;
      EX1_DR:  return tms ? UPD_DR : PAU_DR;
      PAU_DR:  return tms ? EX2_DR : PAU_DR;
      EX2_DR:  return tms ? UPD_DR : SH_DR;
      UPD_DR:  return tms ? SEL_DR : RTI;
      SEL_IR:  return tms ? TLR    : CAP_IR;
      CAP_IR:  return tms ? EX1_IR : SH_IR;
      SH_IR:   return tms ? EX1_IR : SH_IR;
      EX1_IR:  return tms ? UPD_IR : PAU_IR;
      PAU_IR:  return tms ? EX2_IR : PAU_IR;
      EX2_IR:  return tms ? UPD_IR : SH_IR;
      UPD_IR:  return tms ? SEL_DR : RTI;
      default: return TLR;
    endcase
  endfunction

  tap_t        tap_st = TLR;
  logic [5:0]  tap_ir = 6'h09;
  logic [5:0]  ir_sr  = 6'h00;
  logic [31:0] dr_sr  = 32'h0;
  logic        tdo_r  = 1'b0;

  assign jtag_tdo = tdo_r;

  always @(posedge jtag_tck) begin
    case (tap_st)
      TLR:     tap_ir <= 6'h09;
      CAP_DR:  dr_sr  <= (tap_ir == 6'h09) ? IDCODE : 32'h0;
      SH_DR:   dr_sr  <= {jtag_tdi, dr_sr[31:1]};
      CAP_IR:  ir_sr  <= 6'b000001;
      SH_IR:   ir_sr  <= {jtag_tdi, ir_sr[5:1]};
      UPD_IR:  tap_ir <= ir_sr;
      default: ;
    endcase
    tap_st <= tap_next(tap_st, jtag_tms);
  end

  always @(negedge jtag_tck) begin
    if (tap_st == SH_DR)      tdo_r <= dr_sr[0];
    else if (tap_st == SH_IR) tdo_r <= ir_sr[0];
  end

  // ---------------- monitors ----------------
  int   tck_cnt = 0;
  int   rsp_cnt = 0;
  logic tms_log[$];
  logic tdi_log[$];

  always @(posedge jtag_tck) begin
    tck_cnt++;
    tms_log.push_back(jtag_tms);
    tdi_log.push_back(jtag_tdi);
  end

  always @(negedge clock) begin
    if (rsp_valid) rsp_cnt++;
  end

  // ---------------- scoreboard ----------------
  int           n_pass  = 0;
  int           n_total = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic score_rsp(input string name);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: got %h with no expected response queued", name, rsp_data);
    end else begin
      e = exp_q.pop_front();
      check(name, rsp_data, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_rsp(output int cyc, output bit got);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 1000) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      got = rsp_valid;
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [6:0] len, input logic [W-1:0] data,
                         output int cyc, output int tcks, output bit got);
    int base;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    base = tck_cnt;
    wait_rsp(cyc, got);
    tcks = tck_cnt - base;
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [6:0]   len;
    logic [W-1:0] data;
    int           exp_tcks;
    int           exp_cyc;
    logic [W-1:0] exp_rsp;
  } vec_t;

  initial begin
    vec_t        vecs[7];
    int          cyc;
    int          tcks;
    int          base;
    int          lbase;
    int          rbase;
    int          guard;
    bit          got;
    logic [15:0] pk;

    // latency = 1 + 2*T*CLK_DIV with CLK_DIV = 2
    vecs[0] = '{OP_RESET, 7'd0,  64'h0,                 6,  25, 64'h0};
    vecs[1] = '{OP_DR,    7'd32, 64'hFFFF_FFFF,         37, 149, {32'h0, IDCODE}};
    vecs[2] = '{OP_IR,    7'd6,  64'h09,                12, 49, 64'h01};
    vecs[3] = '{OP_IDLE,  7'd3,  64'hFFFF,              3,  13, 64'h0};
    vecs[4] = '{OP_DR,    7'd8,  64'hA5,                13, 53, 64'h48};
    vecs[5] = '{OP_IDLE,  7'd0,  64'h0,                 1,  5,  64'h0};
    vecs[6] = '{OP_DR,    7'd40, 64'hFFFF_FF5A_0000_0000 | 64'h5A, 45, 181, 64'h0000_005A_14D5_7048};

    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_len   = 7'd0;
    cmd_data  = '0;

    // ---- reset values ----
    #1 resetb = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("rst jtag tck/tms/tdi", {jtag_tck, jtag_tms, jtag_tdi}, 3'b111);
    check("rst ready/busy/valid", {cmd_ready, busy, rsp_valid}, 3'b100);
    check("rst rsp_data", rsp_data, 64'h0);
    check("rst state", dbg_state, 2'd0);
    resetb = 1'b1;
    base = tck_cnt;
    repeat (20) @(negedge clock);
    check("idle tck edges", tck_cnt - base, 0);
    check("idle tck level", jtag_tck, 1'b1);

    // ---- directed command table ----
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(vecs[i].exp_rsp);
      run_cmd(vecs[i].op, vecs[i].len, vecs[i].data, cyc, tcks, got);
      check($sformatf("vec%0d latency", i), cyc, vecs[i].exp_cyc);
      check($sformatf("vec%0d tck count", i), tcks, vecs[i].exp_tcks);
      if (got) score_rsp($sformatf("vec%0d rsp_data", i));
      else void'(exp_q.pop_front());
      check($sformatf("vec%0d ready/busy/tck at rsp", i), {cmd_ready, busy, jtag_tck}, 3'b101);
      @(negedge clock);
      check($sformatf("vec%0d rsp pulse width", i), rsp_valid, 1'b0);
      check($sformatf("vec%0d rsp hold", i), rsp_data, vecs[i].exp_rsp);
    end
    check("tap idle after table", tap_st, RTI);

    // ---- TAP_RESET TMS pattern ----
    lbase = tms_log.size();
    exp_q.push_back(64'h0);
    run_cmd(OP_RESET, 7'd0, 64'h0, cyc, tcks, got);
    if (got) score_rsp("tap_reset rsp_data");
    pk = '0;
    for (int j = 0; j < 6; j++) if (lbase + j < tms_log.size()) pk[j] = tms_log[lbase + j];
    check("tap_reset tms seq", pk, 16'h001F);
    check("tap_reset latency", cyc, 25);
    check("tap_reset tap state", tap_st, RTI);

    // ---- IR shift ----
    lbase = tms_log.size();
    exp_q.push_back(64'h01);
    run_cmd(OP_IR, 7'd6, 64'h09, cyc, tcks, got);
    if (got) score_rsp("ir rsp_data");
    check("ir tck count", tcks, 12);
    pk = '0;
    for (int j = 0; j < 12; j++) if (lbase + j < tms_log.size()) pk[j] = tms_log[lbase + j];
    check("ir tms seq", pk, 16'h0603);
    pk = '0;
    for (int j = 0; j < 12; j++) if (lbase + j < tdi_log.size()) pk[j] = tdi_log[lbase + j];
    check("ir tdi seq", pk, 16'h0C9F);
    check("ir tdi shift bits", pk[9:4], 6'h09);
    check("ir model register", tap_ir, 6'h09);
    check("ir tap state", tap_st, RTI);

    // ---- back-to-back with clamping ----
    exp_q.push_back(64'h0);
    exp_q.push_back({32'h1234_5678, IDCODE});
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op    = OP_IDLE;
    cmd_len   = 7'd0;
    cmd_data  = '0;
    @(posedge clock);
    #1;
    cmd_op   = OP_DR;
    cmd_len  = 7'd100;
    cmd_data = 64'hA5A5_5A5A_1234_5678;
    base = tck_cnt;
    wait_rsp(cyc, got);
    check("b2b first latency", cyc, 5);
    check("b2b first tck count", tck_cnt - base, 1);
    check("b2b ready in rsp cycle", cmd_ready, 1'b1);
    if (got) score_rsp("b2b first rsp_data");
    base = tck_cnt;
    @(posedge clock);
    #1;
    check("b2b second accepted", busy, 1'b1);
    cmd_valid = 1'b0;
    wait_rsp(cyc, got);
    check("b2b second latency", cyc, 277);
    check("b2b second tck count", tck_cnt - base, 69);
    if (got) score_rsp("b2b second rsp_data");
    check("b2b tap state", tap_st, RTI);

    // ---- reset in the middle of a DR shift ----
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op    = OP_DR;
    cmd_len   = 7'd32;
    cmd_data  = 64'hFFFF_FFFF;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    base  = tck_cnt;
    rbase = rsp_cnt;
    guard = 0;
    while (!((tck_cnt - base == 13) && !jtag_tck) && guard < 1000) begin
      @(negedge clock);
      guard++;
    end
    check("midreset reached bit 10", guard < 1000, 1'b1);
    #1 resetb = 1'b0;
    #1;
    check("midreset jtag tck/tms/tdi", {jtag_tck, jtag_tms, jtag_tdi}, 3'b111);
    check("midreset ready/busy/valid", {cmd_ready, busy, rsp_valid}, 3'b100);
    check("midreset rsp_data", rsp_data, 64'h0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    resetb = 1'b1;
    repeat (10) @(negedge clock);
    check("midreset no rsp", rsp_cnt - rbase, 0);
    check("midreset queue empty", exp_q.size(), 0);

    exp_q.push_back(64'h0);
    run_cmd(OP_RESET, 7'd0, 64'h0, cyc, tcks, got);
    if (got) score_rsp("post-reset tap_reset rsp");
    check("post-reset tap_reset tcks", tcks, 6);
    exp_q.push_back({32'h0, IDCODE});
    run_cmd(OP_DR, 7'd32, 64'hFFFF_FFFF, cyc, tcks, got);
    if (got) score_rsp("post-reset idcode rsp");
    check("post-reset idcode tcks", tcks, 37);
    check("post-reset tap state", tap_st, RTI);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
